// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } m_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CALC  = 2'b01,
    FIXUP = 2'b10,
    DONE  = 2'b11
  } seq_state_e;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  function automatic logic op_is_div(m_op_e op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

  function automatic logic op_a_signed(m_op_e op);
    return op inside {MUL, MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic op_b_signed(m_op_e op);
    return op inside {MUL, MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Radix-2 iterative multiply/divide sequencer for the RV32M ops.
// One shift-add or restoring shift-subtract step per cycle on operand
// magnitudes; signs are re-applied in FIXUP.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             stall_o
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  seq_state_e          state_q;
  logic [CW-1:0]       cnt_q;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]    mag_b_q;
  m_op_e               op_q;
  logic                neg_res_q, neg_rem_q, raw_q, done_q;
  logic [WIDTH-1:0]    result_q, result_d;

  m_op_e               op_in;
  logic                sa_in, sb_in, div0_in, ovf_in;
  logic [WIDTH-1:0]    mag_a_in, mag_b_in;
  logic [WIDTH:0]      mul_sum, div_trial;
  logic [2*WIDTH-1:0]  prod;
  logic [WIDTH-1:0]    quo, rem;

  // Decode the incoming op: effective signs, magnitudes and short-circuit cases.
  always_comb begin
    op_in    = m_op_e'(funct3_i);
    sa_in    = op_a_signed(op_in) & op_a_i[WIDTH-1];
    sb_in    = op_b_signed(op_in) & op_b_i[WIDTH-1];
    mag_a_in = sa_in ? -op_a_i : op_a_i;
    mag_b_in = sb_in ? -op_b_i : op_b_i;
    div0_in  = op_is_div(op_in) && (op_b_i == '0);
    ovf_in   = (op_in == DIV || op_in == REM) && (op_a_i == MIN_NEG) && (op_b_i == '1);
  end

  // One iteration: acc = {hi, lo}. Multiply adds into hi and shifts right;
  // divide shifts left and subtracts the divisor when it fits.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b_q};
    if (op_is_div(op_q)) begin
      if (!div_trial[WIDTH]) acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                   acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Sign fixup and field selection; short-circuit results bypass the sign fix.
  always_comb begin
    prod = neg_res_q ? -acc_q : acc_q;
    quo  = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];
    if (!raw_q) begin
      if (neg_res_q) quo = -acc_q[WIDTH-1:0];
      if (neg_rem_q) rem = -acc_q[2*WIDTH-1:WIDTH];
    end
    result_d = rem;
    case (op_q)
      MUL:                 result_d = prod[WIDTH-1:0];
      MULH, MULHSU, MULHU: result_d = prod[2*WIDTH-1:WIDTH];
      DIV, DIVU:           result_d = quo;
      default:             result_d = rem;
    endcase
  end

  // Sequencer FSM with counter, work registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mag_b_q   <= '0;
      op_q      <= MUL;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      raw_q     <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            op_q      <= op_in;
            mag_b_q   <= mag_b_in;
            neg_res_q <= sa_in ^ sb_in;
            neg_rem_q <= sa_in;
            cnt_q     <= CW'(WIDTH - 1);
            // Short-circuit results are preloaded as {remainder, quotient}.
            if (div0_in) begin
              acc_q   <= {op_a_i, {WIDTH{1'b1}}};
              raw_q   <= 1'b1;
              state_q <= FIXUP;
            end else if (ovf_in) begin
              acc_q   <= {{WIDTH{1'b0}}, MIN_NEG};
              raw_q   <= 1'b1;
              state_q <= FIXUP;
            end else begin
              acc_q   <= {{WIDTH{1'b0}}, mag_a_in};
              raw_q   <= 1'b0;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          acc_q <= acc_d;
          if (cnt_q == '0) state_q <= FIXUP;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        FIXUP: begin
          result_q <= result_d;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign done_o   = done_q;
  assign result_o = result_q;
  assign stall_o  = rst_n & start_i & ~done_q;

endmodule
